// File: rtl/ita_tcdm_responder.sv
// ita_tcdm_responder: single-port TCDM slave memory with in-order read responses.
// Reads go through a LATENCY-stage valid pipeline into a fall-through response
// FIFO. Grants are throttled so that granted-but-unpopped reads never exceed
// FIFO_DEPTH. Define ITA_TCDM_RESP_STALL_EN to add LFSR-driven grant stalls.
module ita_tcdm_responder #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int IW         = 8,
  parameter int NUM_WORDS  = 1024,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int OCW       = $clog2(FIFO_DEPTH+1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            tcdm_req_i,
  output logic            tcdm_gnt_o,
  input  logic [AW-1:0]   tcdm_add_i,
  input  logic            tcdm_wen_i,
  input  logic [DW/8-1:0] tcdm_be_i,
  input  logic [DW-1:0]   tcdm_data_i,
  input  logic [IW-1:0]   tcdm_id_i,
  output logic            tcdm_r_valid_o,
  input  logic            tcdm_r_ready_i,
  output logic [DW-1:0]   tcdm_r_data_o,
  output logic [IW-1:0]   tcdm_r_id_o,
  output logic [OCW-1:0]  outstanding_o
);

  localparam int BW  = DW/8;
  localparam int OFS = $clog2(BW);
  localparam int IXW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic           stall, flush;
  logic           rd_acc, wr_acc, pop;
  logic [IXW-1:0] idx;
  logic           unused_add;

  logic [DW-1:0]  mem [NUM_WORDS];

  logic           push_vld;
  logic [DW-1:0]  push_dat;
  logic [IW-1:0]  push_id;

  logic [DW-1:0]  f_dat [FIFO_DEPTH];
  logic [IW-1:0]  f_id  [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [OCW-1:0] f_cnt;

  assign flush      = rst_i | clear_i;
  assign idx        = tcdm_add_i[OFS +: IXW];
  assign unused_add = ^tcdm_add_i;

`ifdef ITA_TCDM_RESP_STALL_EN
  logic [15:0] lfsr;
  // Fibonacci LFSR (taps 16,14,13,11); only the hard reset reseeds it
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Reads are held off once every response slot is spoken for; writes never are
  assign tcdm_gnt_o = tcdm_req_i && !flush && !stall &&
                      (!tcdm_wen_i || (outstanding_o < OCW'(FIFO_DEPTH)));
  assign rd_acc     = tcdm_gnt_o &&  tcdm_wen_i;
  assign wr_acc     = tcdm_gnt_o && !tcdm_wen_i;
  assign pop        = tcdm_r_valid_o && tcdm_r_ready_i;

  // Byte-masked write; contents deliberately survive reset and clear
  always_ff @(posedge clk_i) begin
    if (wr_acc)
      for (int b = 0; b < BW; b++)
        if (tcdm_be_i[b]) mem[idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
  end

  // Read word is sampled on the grant edge; the last stage writes the FIFO,
  // so the response is visible LATENCY cycles after acceptance
  if (LATENCY == 1) begin : g_lat1
    assign push_vld = rd_acc;
    assign push_dat = mem[idx];
    assign push_id  = tcdm_id_i;
  end else begin : g_pipe
    logic [LATENCY-2:0]         vld_pipe;
    logic [LATENCY-2:0][DW-1:0] dat_pipe;
    logic [LATENCY-2:0][IW-1:0] id_pipe;
    // Shift read valid/data/id toward the FIFO; flush drops in-flight reads
    always_ff @(posedge clk_i) begin
      if (flush) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= rd_acc;
        dat_pipe[0] <= mem[idx];
        id_pipe[0]  <= tcdm_id_i;
        for (int s = 1; s < LATENCY-1; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          dat_pipe[s] <= dat_pipe[s-1];
          id_pipe[s]  <= id_pipe[s-1];
        end
      end
    end
    assign push_vld = vld_pipe[LATENCY-2];
    assign push_dat = dat_pipe[LATENCY-2];
    assign push_id  = id_pipe[LATENCY-2];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Response FIFO; outstanding accounting guarantees a push never meets a full
  // FIFO unless the head is leaving in the same cycle
  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      if (push_vld) begin
        f_dat[wr_ptr] <= push_dat;
        f_id[wr_ptr]  <= push_id;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push_vld && !pop)      f_cnt <= f_cnt + 1'b1;
      else if (pop && !push_vld) f_cnt <= f_cnt - 1'b1;
    end
  end

  // Reads granted but not yet handed back to the initiator
  always_ff @(posedge clk_i) begin
    if (flush)                outstanding_o <= '0;
    else if (rd_acc && !pop)  outstanding_o <= outstanding_o + 1'b1;
    else if (pop && !rd_acc)  outstanding_o <= outstanding_o - 1'b1;
  end

  assign tcdm_r_valid_o = (f_cnt != '0);
  assign tcdm_r_data_o  = tcdm_r_valid_o ? f_dat[rd_ptr] : '0;
  assign tcdm_r_id_o    = tcdm_r_valid_o ? f_id[rd_ptr]  : '0;

endmodule
